// File: rtl/aes_irq_pkg.sv
// Shared constants, bus-strobe struct and priority helper for the AES interrupt controller.
package aes_irq_pkg;

  localparam int DATA_W = 16;
  localparam int VEC_W  = 4;
  localparam logic [DATA_W-1:0] COUNT_MAX = 16'hFFFF;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_ENABLE  = 3'd2;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
  localparam logic [2:0] ADDR_VECTOR  = 3'd4;
  localparam logic [2:0] ADDR_FORCE   = 3'd5;
  localparam logic [2:0] ADDR_COUNT   = 3'd6;

  typedef struct packed {
    logic w1c;
    logic en;
    logic frc;
    logic cnt_clr;
  } irq_wr_t;

  // Index 0 has highest priority; returns 0 when nothing is set.
  function automatic logic [VEC_W-1:0] lowest_set_index(input logic [DATA_W-1:0] v);
    logic [VEC_W-1:0] idx;
    idx = '0;
    for (int i = DATA_W - 1; i >= 0; i--)
      if (v[i]) idx = VEC_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/aes_irq_sync.sv
// Parameterised two-flop synchroniser, flops reset to 0.
module aes_irq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/aes_irq_ctrl.sv
// Avalon-MM interrupt controller: edge/level capture, mask, force, priority vector, event counter.
// Define IRQ_CTRL_SYNC_EN to pass irq_in through a 2-flop synchroniser.
module aes_irq_ctrl import aes_irq_pkg::*; #(
  parameter int                 NUM_IRQ   = 8,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = NUM_IRQ'(8'h01)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic               irq
);

  if (NUM_IRQ < 1 || NUM_IRQ > 16) begin : g_bad_num_irq
    $error("aes_irq_ctrl: NUM_IRQ must be 1..16");
  end

  logic [NUM_IRQ-1:0] in_s;
  logic [NUM_IRQ-1:0] prev;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] pending_nxt;
  logic [NUM_IRQ-1:0] enable;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] wdata_n;
  logic [NUM_IRQ-1:0] w1c_mask;
  logic [NUM_IRQ-1:0] frc_mask;
  logic [DATA_W-1:0]  count;
  logic [DATA_W-1:0]  vector;
  logic [DATA_W-1:0]  rd_mux;
  logic               any_rise;
  logic               unused_wd;
  irq_wr_t            wr;

`ifdef IRQ_CTRL_SYNC_EN
  aes_irq_sync #(.WIDTH(NUM_IRQ)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (irq_in),
    .q       (in_s)
  );
`else
  assign in_s = irq_in;
`endif

  // Write decode; upper writedata bits beyond NUM_IRQ have no effect.
  always_comb begin
    wr         = '0;
    wr.w1c     = chipselect && !write_n && (address == ADDR_PENDING);
    wr.en      = chipselect && !write_n && (address == ADDR_ENABLE);
    wr.frc     = chipselect && !write_n && (address == ADDR_FORCE);
    wr.cnt_clr = chipselect && !write_n && (address == ADDR_COUNT);
  end

  assign wdata_n   = writedata[NUM_IRQ-1:0];
  assign unused_wd = |(writedata & ~DATA_W'({NUM_IRQ{1'b1}}));
  assign w1c_mask  = wr.w1c ? (wdata_n & EDGE_MASK) : '0;
  assign frc_mask  = wr.frc ? (wdata_n & EDGE_MASK) : '0;
  assign rise      = in_s & ~prev & EDGE_MASK;
  assign any_rise  = |rise;
  assign active    = pending & enable;

  // Edge sources are sticky with set-over-clear; level sources track in_s.
  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_src
    if (EDGE_MASK[i]) begin : g_edge
      assign pending_nxt[i] = rise[i] | frc_mask[i] | (pending[i] & ~w1c_mask[i]);
    end else begin : g_level
      assign pending_nxt[i] = in_s[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev    <= '0;
      pending <= '0;
      enable  <= '0;
      irq     <= 1'b0;
    end else begin
      prev    <= in_s;
      pending <= pending_nxt;
      if (wr.en) enable <= wdata_n;
      irq     <= |active;
    end
  end

  // One count per cycle with any edge event; a clear that collides with an event leaves 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (wr.cnt_clr)
      count <= any_rise ? DATA_W'(1) : '0;
    else if (any_rise && count != COUNT_MAX)
      count <= count + DATA_W'(1);
  end

  assign vector = {|active, {(DATA_W-1-VEC_W){1'b0}}, lowest_set_index(DATA_W'(active))};

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_STATUS:  rd_mux = DATA_W'(in_s);
      ADDR_PENDING: rd_mux = DATA_W'(pending);
      ADDR_ENABLE:  rd_mux = DATA_W'(enable);
      ADDR_ACTIVE:  rd_mux = DATA_W'(active);
      ADDR_VECTOR:  rd_mux = vector;
      ADDR_COUNT:   rd_mux = count;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

endmodule

// File: tb/tb_aes_irq_ctrl.sv
// Bench for aes_irq_ctrl: directed vector table, reset/saturation sequences, random stimulus vs model.
module tb_aes_irq_ctrl;

  localparam int N = 8;
  localparam logic [N-1:0] EM = 8'h09;
`ifdef IRQ_CTRL_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  irq_in = '0;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [15:0]   writedata = '0;
  logic [15:0]   readdata;
  logic          irq;

  int n_chk = 0;
  int n_err = 0;

  aes_irq_ctrl #(.NUM_IRQ(N), .EDGE_MASK(EM)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .irq_in     (irq_in),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [N-1:0] m_pend, m_en, m_prev, m_s1, m_s2;
  int           m_cnt;
  logic [15:0]  m_rd;
  logic         m_irq;

  typedef struct {
    logic        cs;
    logic        wr_n;
    logic [2:0]  addr;
    logic [15:0] wd;
    logic [N-1:0] in;
    logic [15:0] rd;
    logic        irq;
  } vec_t;
  vec_t tbl[$];

  function automatic void check(string nm, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic m_reset();
    m_pend = '0; m_en = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
    m_cnt = 0; m_rd = '0; m_irq = 1'b0;
  endtask

  function automatic logic [15:0] model_read(logic [2:0] a, logic [N-1:0] ins);
    logic [N-1:0] act;
    int k;
    act = m_pend & m_en;
    case (a)
      3'd0: return 16'(ins);
      3'd1: return 16'(m_pend);
      3'd2: return 16'(m_en);
      3'd3: return 16'(act);
      3'd4: begin
        if (act == '0) return 16'h0000;
        k = 0;
        while (!act[k]) k++;
        return 16'h8000 + 16'(k);
      end
      3'd6: return 16'(m_cnt);
      default: return 16'h0000;
    endcase
  endfunction

  // One clock: predict from the rules, advance, then compare away from the edge.
  task automatic tick();
    logic [N-1:0] ins, np;
    logic [15:0]  nrd;
    logic         nirq, w, any;
    int           nc;
    ins  = SYNC ? m_s2 : irq_in;
    nrd  = model_read(address, ins);
    nirq = |(m_pend & m_en);
    w    = chipselect && !write_n;
    any  = 1'b0;
    np   = m_pend;
    for (int i = 0; i < N; i++) begin
      if (EM[i]) begin
        if (ins[i] && !m_prev[i]) any = 1'b1;
        if (w && address == 3'd1 && writedata[i]) np[i] = 1'b0;
        if ((ins[i] && !m_prev[i]) || (w && address == 3'd5 && writedata[i])) np[i] = 1'b1;
      end else begin
        np[i] = ins[i];
      end
    end
    nc = m_cnt;
    if (w && address == 3'd6) nc = any ? 1 : 0;
    else if (any && nc < 65535) nc = nc + 1;
    @(posedge clk);
    if (w && address == 3'd2) m_en = writedata[N-1:0];
    m_pend = np; m_prev = ins; m_cnt = nc;
    m_s2 = m_s1; m_s1 = irq_in;
    m_rd = nrd; m_irq = nirq;
    #1;
    check("model readdata", readdata, m_rd);
    check("model irq", {15'b0, irq}, {15'b0, m_irq});
  endtask

  task automatic drive(logic cs, logic wr_n, logic [2:0] a, logic [15:0] wd, logic [N-1:0] in);
    chipselect = cs; write_n = wr_n; address = a; writedata = wd; irq_in = in;
  endtask

  task automatic r_row(logic [2:0] a, logic [N-1:0] in, logic [15:0] rd, logic ir);
    tbl.push_back('{1'b0, 1'b1, a, 16'h0, in, rd, ir});
  endtask

  task automatic w_row(logic [2:0] a, logic [15:0] wd, logic [N-1:0] in, logic [15:0] rd, logic ir);
    tbl.push_back('{1'b1, 1'b0, a, wd, in, rd, ir});
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check("reset readdata", readdata, 16'h0000);
    check("reset irq", {15'b0, irq}, 16'h0000);

`ifndef IRQ_CTRL_SYNC_EN
    // Expected rd/irq are the values seen just after each row's clock edge.
    for (int a = 0; a < 8; a++) r_row(3'(a), 8'h00, 16'h0000, 1'b0);
    w_row(2, 16'h0001, 8'h00, 16'h0000, 0);
    r_row(1, 8'h01, 16'h0000, 0);
    r_row(1, 8'h00, 16'h0001, 1);
    r_row(4, 8'h00, 16'h8000, 1);
    r_row(6, 8'h00, 16'h0001, 1);
    w_row(1, 16'h0001, 8'h00, 16'h0001, 1);
    r_row(1, 8'h00, 16'h0000, 0);
    w_row(2, 16'h0003, 8'h00, 16'h0001, 0);
    r_row(0, 8'h02, 16'h0002, 0);
    r_row(4, 8'h02, 16'h8001, 1);
    w_row(1, 16'h0002, 8'h02, 16'h0002, 1);
    r_row(1, 8'h02, 16'h0002, 1);
    r_row(1, 8'h00, 16'h0002, 1);
    r_row(1, 8'h00, 16'h0000, 0);
    r_row(1, 8'h01, 16'h0000, 0);
    r_row(1, 8'h00, 16'h0001, 1);
    w_row(1, 16'h0001, 8'h01, 16'h0001, 1);
    r_row(1, 8'h00, 16'h0001, 1);
    r_row(6, 8'h00, 16'h0003, 1);
    w_row(2, 16'h0005, 8'h04, 16'h0003, 1);
    r_row(4, 8'h04, 16'h8000, 1);
    w_row(1, 16'h0001, 8'h04, 16'h0005, 1);
    r_row(4, 8'h04, 16'h8002, 1);
    w_row(5, 16'h0004, 8'h00, 16'h0000, 1);
    r_row(1, 8'h00, 16'h0000, 0);
    w_row(5, 16'h0001, 8'h00, 16'h0000, 0);
    r_row(1, 8'h00, 16'h0001, 1);
    r_row(6, 8'h00, 16'h0003, 1);
    w_row(2, 16'h0000, 8'h00, 16'h0005, 1);
    r_row(3, 8'h00, 16'h0000, 0);
    r_row(1, 8'h00, 16'h0001, 0);
    w_row(2, 16'h0001, 8'h00, 16'h0000, 0);
    r_row(3, 8'h00, 16'h0001, 1);
    w_row(1, 16'h0001, 8'h00, 16'h0001, 1);
    r_row(7, 8'h00, 16'h0000, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].cs, tbl[i].wr_n, tbl[i].addr, tbl[i].wd, tbl[i].in);
      tick();
      check($sformatf("vec%0d readdata", i), readdata, tbl[i].rd);
      check($sformatf("vec%0d irq", i), {15'b0, irq}, {15'b0, tbl[i].irq});
    end
`endif

    // Asynchronous reset while an interrupt is pending and asserted.
    drive(1, 0, 2, 16'h0001, 8'h00); tick();
    drive(0, 1, 1, 16'h0000, 8'h01); tick();
    drive(0, 1, 1, 16'h0000, 8'h00); repeat (4) tick();
    check("pre-reset irq", {15'b0, irq}, 16'h0001);
    #2 reset_n = 1'b0;
    #1;
    check("async reset readdata", readdata, 16'h0000);
    check("async reset irq", {15'b0, irq}, 16'h0000);
    m_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    drive(0, 1, 1, 16'h0000, 8'h00); tick(); tick();
    check("post-reset pending", readdata, 16'h0000);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      drive(1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), 16'($urandom), N'($urandom));
      tick();
    end

    // Counter saturation: alternate two edge sources so every cycle carries an event.
    drive(0, 1, 0, 16'h0000, 8'h00); repeat (3) tick();
    drive(1, 0, 6, 16'h0000, 8'h00); tick();
    for (int j = 0; j < 65538; j++) begin
      drive(0, 1, 6, 16'h0000, (j % 2 == 0) ? 8'h01 : 8'h08);
      tick();
    end
    drive(0, 1, 6, 16'h0000, 8'h00); repeat (3) tick();
    check("count saturated", readdata, 16'hFFFF);
    drive(0, 1, 6, 16'h0000, 8'h01); tick();
    drive(0, 1, 6, 16'h0000, 8'h00); repeat (3) tick();
    check("count stays saturated", readdata, 16'hFFFF);
    drive(1, 0, 6, 16'h0000, 8'h01); tick();
    drive(0, 1, 6, 16'h0000, 8'h00); tick();
`ifndef IRQ_CTRL_SYNC_EN
    check("count clear with edge", readdata, 16'h0001);
`endif
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
